pipelined_mem_responder: RTL and testbench



---
 rtl/pipelined_mem_responder_pkg.sv | 31 +++
 rtl/pipelined_mem_responder_mem_resp_pipe.sv | 55 +++++
 rtl/pipelined_mem_responder.sv | 93 +++++++++
 tb/tb_pipelined_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_mem_responder_pkg.sv
// Shared memory-side definitions for the cache miss path.
//   WORD_W          : data word width of the responder array.
//   DEFAULT_LATENCY : read latency of the responder, reused by the fill FSM
//                     word counter so both ends agree on response timing.
//   req_kind_e      : decoded request class of the enable/wr strobe pair.
//   decode_req()    : maps {enable, wr} onto req_kind_e.
package pipelined_mem_responder_pkg;

  localparam int WORD_W          = 16;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_RD   = 2'd1,
    REQ_WR   = 2'd2
  } req_kind_e;

  // wr is only meaningful while enable is high.
  function automatic req_kind_e decode_req(input logic enable_i, input logic wr_i);
    req_kind_e kind;
    if (!enable_i) begin
      kind = REQ_IDLE;
    end else if (wr_i) begin
      kind = REQ_WR;
    end else begin
      kind = REQ_RD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/pipelined_mem_responder_mem_resp_pipe.sv
// LATENCY-stage response shift register carrying {valid, data, addr}.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high clear.
//   in_valid_i  : a read was issued at this edge.
//   in_data_i   : word sampled from the array at the issue edge.
//   in_addr_i   : byte address of the read (bit 0 dropped on entry).
//   out_valid_o : response strobe, LATENCY edges after issue (registered).
//   out_data_o  : response data, 0 when out_valid_o is low.
//   out_addr_o  : response address with bit 0 cleared, 0 when idle.
module mem_resp_pipe
  import pipelined_mem_responder_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [WORD_W-1:0]     in_data_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  output logic                  out_valid_o,
  output logic [WORD_W-1:0]     out_data_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(1);

  logic [LATENCY-1:0]                 vld_q;
  logic [LATENCY-1:0][WORD_W-1:0]     data_q;
  logic [LATENCY-1:0][ADDR_WIDTH-1:0] addr_q;

  // Shift stages; payload is zeroed on entry for empty slots so the last
  // stage can drive the outputs directly and still read 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      vld_q[0]  <= in_valid_i;
      data_q[0] <= in_valid_i ? in_data_i : '0;
      addr_q[0] <= in_valid_i ? (in_addr_i & ADDR_MASK) : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[LATENCY-1];
  assign out_data_o  = data_q[LATENCY-1];
  assign out_addr_o  = addr_q[LATENCY-1];

endmodule

// File: rtl/pipelined_mem_responder.sv
// Memory-side responder: single-port word array with a fixed-latency,
// fully pipelined read path (one request per cycle, in-order responses).
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset.
//   enable, wr  : request strobe and direction (1 = write).
//   addr        : byte address, bit 0 ignored, word index wraps at DEPTH_WORDS.
//   data_in     : write data, committed at the issue edge.
//   data_out    : read data, 0 unless data_valid.
//   data_valid  : one-cycle response strobe per read.
//   resp_addr   : address being answered (bit 0 = 0), 0 unless data_valid.
//   outstanding : reads issued but not yet answered.
module pipelined_mem_responder
  import pipelined_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 32768,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     data_in,
  output logic [WORD_W-1:0]     data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [3:0]            outstanding
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  req_kind_e         kind_s;
  logic              rd_issue_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WORD_W-1:0] rd_word_s;
  logic [3:0]        outstanding_d;
  logic [3:0]        outstanding_q;

  assign kind_s     = decode_req(enable, wr);
  assign rd_issue_s = (kind_s == REQ_RD);
  // Out-of-range word addresses alias back into the array.
  assign idx_s      = IDX_W'(32'(addr[ADDR_WIDTH-1:1]) % DEPTH_WORDS);
  // Sampled into the pipe at the issue edge, so an in-flight read keeps the
  // pre-write value even if a later write hits the same word.
  assign rd_word_s  = mem_q[idx_s];

  // Write port; the array itself is never cleared and ignores requests
  // while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && (kind_s == REQ_WR)) begin
      mem_q[idx_s] <= data_in;
    end
  end

  mem_resp_pipe #(
    .LATENCY    (LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_issue_s),
    .in_data_i   (rd_word_s),
    .in_addr_i   (addr),
    .out_valid_o (data_valid),
    .out_data_o  (data_out),
    .out_addr_o  (resp_addr)
  );

  // Next outstanding count: issue and retire in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_issue_s, data_valid})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= 4'd0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
module tb_pipelined_mem_responder;
  import pipelined_mem_responder_pkg::*;

  localparam int AW    = 16;
  localparam int DEPTH = 32768;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, wr;
  logic [15:0] addr, data_in;
  logic [15:0] data_out, resp_addr;
  logic        data_valid;
  logic [3:0]  outstanding;

  logic        enable_a, wr_a;
  logic [15:0] addr_a, data_in_a;
  logic [15:0] data_out_a, resp_addr_a;
  logic        data_valid_a;
  logic [3:0]  outstanding_a;

  pipelined_mem_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .resp_addr(resp_addr),
    .outstanding(outstanding)
  );

  pipelined_mem_responder #(.ADDR_WIDTH(AW), .DEPTH_WORDS(256), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .wr(wr_a), .addr(addr_a), .data_in(data_in_a),
    .data_out(data_out_a), .data_valid(data_valid_a), .resp_addr(resp_addr_a),
    .outstanding(outstanding_a)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  // Each read becomes a queued response due at edge (issue edge + LAT - 1);
  // outstanding is simply the number of queued responses not yet retired.
  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
  } resp_t;

  resp_t       rq[$];
  logic [15:0] mem_m [int];
  int          edge_k = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    int    idx;
    resp_t r;
    edge_k++;
    idx = (int'(addr) >> 1) % DEPTH;
    if (rst) begin
      rq.delete();
    end else if (enable) begin
      if (wr) begin
        mem_m[idx] = data_in;
      end else begin
        r.due  = edge_k + LAT - 1;
        r.data = mem_m.exists(idx) ? mem_m[idx] : 16'h0000;
        r.addr = addr & 16'hFFFE;
        rq.push_back(r);
      end
    end
  end

  logic exp_v;
  always @(negedge clk) begin
    if (chk_en) begin
      while (rq.size() > 0 && rq[0].due < edge_k) void'(rq.pop_front());
      exp_v = (rq.size() > 0) && (rq[0].due == edge_k);
      check("model_valid", data_valid, exp_v);
      check("model_data", data_out, exp_v ? rq[0].data : 16'h0000);
      check("model_resp_addr", resp_addr, exp_v ? rq[0].addr : 16'h0000);
      check("model_outstanding", outstanding, rq.size());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    tick();
  endtask

  // Single read issued in cycle 0; response expected in cycle LAT only.
  task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    for (int c = 0; c <= LAT + 2; c++) begin
      check({name, "_valid"}, data_valid, (c == LAT));
      check({name, "_data"}, data_out, (c == LAT) ? exp : 16'h0000);
      check({name, "_addr"}, resp_addr, (c == LAT) ? (a & 16'hFFFE) : 16'h0000);
      check({name, "_outst"}, outstanding, (c >= 1 && c <= LAT) ? 4'd1 : 4'd0);
      if (c == 0) drv(1'b1, 1'b0, a, 16'h0000);
      else        drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  int nvalid;
  int max_out;

  initial begin
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
    enable_a = 1'b0; wr_a = 1'b0; addr_a = 16'h0; data_in_a = 16'h0;
    repeat (3) tick();
    rst = 1'b0;
    // reset state
    check("rst_valid", data_valid, 1'b0);
    check("rst_data", data_out, 16'h0000);
    check("rst_addr", resp_addr, 16'h0000);
    check("rst_outst", outstanding, 4'd0);
    check("rst_a_valid", data_valid_a, 1'b0);
    check("rst_a_outst", outstanding_a, 4'd0);
    chk_en = 1'b1;

    // alias + LATENCY=1 instance (256 words): 0x0202 aliases 0x0002
    enable_a = 1'b1; wr_a = 1'b1; addr_a = 16'h0202; data_in_a = 16'h1234;
    tick();
    check("a_after_wr_valid", data_valid_a, 1'b0);
    wr_a = 1'b0; addr_a = 16'h0002;
    tick();
    check("a_alias_valid", data_valid_a, 1'b1);
    check("a_alias_data", data_out_a, 16'h1234);
    check("a_alias_addr", resp_addr_a, 16'h0002);
    check("a_alias_outst", outstanding_a, 4'd1);
    addr_a = 16'h0203;
    tick();
    check("a_b2b_valid", data_valid_a, 1'b1);
    check("a_b2b_data", data_out_a, 16'h1234);
    check("a_b2b_addr", resp_addr_a, 16'h0202);
    check("a_b2b_outst", outstanding_a, 4'd1);
    enable_a = 1'b0;
    tick();
    check("a_idle_valid", data_valid_a, 1'b0);
    check("a_idle_data", data_out_a, 16'h0000);
    check("a_idle_outst", outstanding_a, 4'd0);

    // preload main array
    drv(1'b1, 1'b1, 16'h0020, 16'hBEEF);
    for (int i = 0; i < 8; i++) drv(1'b1, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1000 + i));
    drv(1'b0, 1'b0, 16'h0000, 16'h0000);

    // single read
    read_check("single", 16'h0020, 16'hBEEF);

    // block fill: 8 back-to-back reads
    nvalid = 0; max_out = 0;
    for (int c = 0; c < 14; c++) begin
      check("blk_valid", data_valid, (c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) check("blk_data", data_out, 16'(16'h1000 + c - 4));
      if (data_valid) nvalid++;
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (c < 8) drv(1'b1, 1'b0, 16'(16'h0040 + 2 * c), 16'h0000);
      else       drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    check("blk_count", nvalid, 8);
    check("blk_peak_outst", max_out, 4);

    // RAW / WAR
    for (int c = 0; c < 12; c++) begin
      check("rawwar_valid", data_valid, (c == 5 || c == 10));
      if (c == 5)  check("raw_data", data_out, 16'hAAAA);
      if (c == 10) check("war_data", data_out, 16'hAAAA);
      case (c)
        0:       drv(1'b1, 1'b1, 16'h0100, 16'hAAAA);
        1, 6:    drv(1'b1, 1'b0, 16'h0100, 16'h0000);
        7:       drv(1'b1, 1'b1, 16'h0100, 16'h5555);
        default: drv(1'b0, 1'b0, 16'h0000, 16'h0000);
      endcase
    end
    read_check("war_after", 16'h0100, 16'h5555);

    // reset with reads in flight, write during reset ignored
    for (int c = 0; c <= 10; c++) begin
      if (c == 3) check("rmf_outst_before", outstanding, 4'd3);
      if (c >= 4) begin
        check("rmf_valid", data_valid, 1'b0);
        check("rmf_data", data_out, 16'h0000);
        check("rmf_addr", resp_addr, 16'h0000);
        check("rmf_outst", outstanding, 4'd0);
      end
      rst = (c == 3);
      if (c < 3)       drv(1'b1, 1'b0, 16'(16'h0040 + 2 * c), 16'h0000);
      else if (c == 3) drv(1'b1, 1'b1, 16'h0020, 16'hDEAD);
      else             drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    read_check("rmf_keep", 16'h0020, 16'hBEEF);

    // idle with don't-care wr/addr/data
    for (int c = 0; c < 20; c++) begin
      check("idle_valid", data_valid, 1'b0);
      check("idle_outst", outstanding, 4'd0);
      drv(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    read_check("idle_keep0", 16'h0040, 16'h1000);
    read_check("idle_keep1", 16'h0020, 16'hBEEF);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
